// File: rtl/serpent_pkg.sv
// rtl/serpent_pkg.sv - Serpent S-box types, FSM states and substitution tables
package serpent_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [2:0] sbox_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Inverse S-boxes used by the decrypt datapath, indexed [sel][nibble].
  localparam nibble_t INV_SBOX [8][16] = '{
    '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
    '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
    '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
    '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
    '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
    '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
    '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
    '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
  };

  // Forward S-boxes, kept alongside the inverse so encrypt-side models share one source.
  localparam nibble_t SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

endpackage

// File: rtl/inv_s_box_nibble.sv
// rtl/inv_s_box_nibble.sv - combinational single-nibble inverse S-box lookup
module inv_s_box_nibble
  import serpent_pkg::*;
(
  input  logic [2:0] i_sel,
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  // Pure table lookup; the table is small enough to collapse into LUT logic.
  always_comb begin
    o_nibble = INV_SBOX[i_sel][i_nibble];
  end

endmodule

// File: rtl/inv_s_box_engine.sv
// rtl/inv_s_box_engine.sv - multi-cycle inverse S-box stage over a 128-bit block
module inv_s_box_engine
  import serpent_pkg::*;
#(
  parameter int NIBBLES_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   sel,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int L     = 32 / NIBBLES_PER_CYCLE;
  localparam int GW    = 4 * NIBBLES_PER_CYCLE;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(L - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  sbox_sel_t         r_sel;
  logic [127:0]      r_work;

  logic              w_accept;
  logic              w_sub;
  logic              w_last;
  logic [7:0]        w_base;
  logic [GW-1:0]     w_group_in;
  logic [GW-1:0]     w_group_out;
  logic [127:0]      w_mask;
  logic [127:0]      w_work_sub;

  // Bit offset of the group being substituted; groups advance from the low end.
  assign w_base      = 8'(r_cnt) * 8'(GW);
  assign w_group_in  = GW'(r_work >> w_base);
  assign w_mask      = ~(128'({GW{1'b1}}) << w_base);
  assign w_work_sub  = (r_work & w_mask) | (128'(w_group_out) << w_base);
  assign w_last      = (r_cnt == LAST_CNT);

  // One lookup per nibble of the active group; all share the latched selector.
  for (genvar j = 0; j < NIBBLES_PER_CYCLE; j++) begin : g_nib
    inv_s_box_nibble u_nib (
      .i_sel    (r_sel),
      .i_nibble (w_group_in[4*j +: 4]),
      .o_nibble (w_group_out[4*j +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; HOLD passes out_ready through to in_ready for back-to-back blocks.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_sub        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = SUB;
        end
      end
      SUB: begin
        w_sub = 1'b1;
        if (w_last) begin
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept     = 1'b1;
            w_next_state = SUB;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Work register: load on acceptance, then rewrite one group per SUB cycle in place.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_work <= '0;
    end else if (w_accept) begin
      r_work <= in_data;
      r_sel  <= sel;
      r_cnt  <= '0;
    end else if (w_sub) begin
      r_work <= w_work_sub;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign out_data = r_work;

endmodule

// File: tb/tb_inv_s_box_engine.sv
// tb/tb_inv_s_box_engine.sv - directed self-checking bench for inv_s_box_engine
module tb_inv_s_box_engine;
  import serpent_pkg::*;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid  [3];
  logic [2:0]   sel_a     [3];
  logic [127:0] in_data_a [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] out_data  [3];

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] ALL_D    = {32{4'hD}};
  localparam logic [127:0] VEC7_IN  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] VEC7_OUT = 128'h306D9EF85CB7A142306D9EF85CB7A142;

  always #5 clk = ~clk;

  // Index 0: N=8 (L=4), index 1: N=1 (L=32), index 2: N=32 (L=1).
  inv_s_box_engine #(.NIBBLES_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .sel(sel_a[0]), .in_data(in_data_a[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0])
  );
  inv_s_box_engine #(.NIBBLES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .sel(sel_a[1]), .in_data(in_data_a[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1])
  );
  inv_s_box_engine #(.NIBBLES_PER_CYCLE(32)) u_dut32 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .sel(sel_a[2]), .in_data(in_data_a[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  function automatic logic [127:0] fwd(input logic [2:0] s, input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[4*k +: 4] = SBOX[s][x[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one block through engine d, scramble inputs after acceptance, return result and latency.
  task automatic run_block(input int d, input logic [2:0] s, input logic [127:0] x,
                           output logic [127:0] y, output int lat, output bit ok);
    int t;
    ok = 1'b1;
    t = 0;
    while (!in_ready[d] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    in_valid[d]  = 1'b1;
    sel_a[d]     = s;
    in_data_a[d] = x;
    out_ready[d] = 1'b0;
    @(posedge clk); #1;
    sel_a[d]     = ~s;
    in_data_a[d] = ~x;
    t = 0;
    while (!out_valid[d] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    in_valid[d] = 1'b0;
    lat = t;
    if (!out_valid[d]) ok = 1'b0;
    y = out_data[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== 128'h0) begin
        failures++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out_data=%h expected 1 0 0",
                 d, in_ready[d], out_valid[d], out_data[d]);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sub;
    in_valid[0]  = 1'b1;
    sel_a[0]     = 3'd0;
    in_data_a[0] = 128'h0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_data[0][31:0] !== 32'hDDDDDDDD) begin
      failures++;
      $display("FAIL partial_sub: low group=%h expected DDDDDDDD", out_data[0][31:0]);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_sub: out_valid=%b out_data=%h in_ready=%b expected 0 0 1",
               out_valid[0], out_data[0], in_ready[0]);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    logic [127:0] y;
    int lat;
    bit ok;
    run_block(0, 3'd0, 128'h0, y, lat, ok);
    checks++;
    if (!ok || lat != 4) begin
      failures++;
      $display("FAIL zero_latency: got %0d ok=%0d expected 4", lat, ok);
    end
    checks++;
    if (y !== ALL_D) begin
      failures++;
      $display("FAIL zero_data: got %h expected %h", y, ALL_D);
    end
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL drain_idle: out_valid=%b in_ready=%b expected 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_sel7;
    logic [127:0] y;
    int lat;
    bit ok;
    run_block(0, 3'd7, VEC7_IN, y, lat, ok);
    checks++;
    if (!ok || y !== VEC7_OUT) begin
      failures++;
      $display("FAIL sel7_data: got %h ok=%0d expected %h", y, ok, VEC7_OUT);
    end
  endtask

  task automatic test_round_trip;
    logic [127:0] x;
    logic [127:0] y;
    int lat;
    bit ok;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 100; i++) begin
        x = rand128();
        run_block(0, 3'(s), fwd(3'(s), x), y, lat, ok);
        checks++;
        if (!ok || y !== x) begin
          failures++;
          $display("FAIL round_trip sel%0d #%0d: got %h ok=%0d expected %h", s, i, y, ok, x);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] xa;
    logic [127:0] xb;
    int t;
    xa = rand128();
    xb = rand128();
    in_valid[0]  = 1'b1;
    sel_a[0]     = 3'd3;
    in_data_a[0] = fwd(3'd3, xa);
    out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== xa) begin
        failures++;
        $display("FAIL hold_stable cyc%0d: out_valid=%b out_data=%h expected 1 %h",
                 c, out_valid[0], out_data[0], xa);
      end
      checks++;
      if (in_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL hold_in_ready cyc%0d: got %b expected 0", c, in_ready[0]);
      end
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    sel_a[0]     = 3'd5;
    in_data_a[0] = fwd(3'd5, xb);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready: got %b expected 1", in_ready[0]);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    in_data_a[0] = '0;
    sel_a[0]     = 3'd0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_in_sub: out_valid=%b in_ready=%b expected 0 0", out_valid[0], in_ready[0]);
    end
    t = 0;
    while (!out_valid[0] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t != 4 || out_data[0] !== xb) begin
      failures++;
      $display("FAIL b2b_second: latency=%0d data=%h expected 4 %h", t, out_data[0], xb);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
  endtask

  task automatic test_param_sweep;
    logic [127:0] x;
    logic [127:0] y;
    int lat;
    bit ok;
    int exp_lat [3] = '{4, 32, 1};
    for (int d = 1; d < 3; d++) begin
      run_block(d, 3'd7, VEC7_IN, y, lat, ok);
      checks++;
      if (!ok || lat != exp_lat[d]) begin
        failures++;
        $display("FAIL sweep_latency dut%0d: got %0d ok=%0d expected %0d", d, lat, ok, exp_lat[d]);
      end
      checks++;
      if (y !== VEC7_OUT) begin
        failures++;
        $display("FAIL sweep_sel7 dut%0d: got %h expected %h", d, y, VEC7_OUT);
      end
      run_block(d, 3'd0, 128'h0, y, lat, ok);
      checks++;
      if (!ok || y !== ALL_D) begin
        failures++;
        $display("FAIL sweep_zero dut%0d: got %h ok=%0d expected %h", d, y, ok, ALL_D);
      end
      for (int s = 0; s < 8; s++) begin
        for (int i = 0; i < 3; i++) begin
          x = rand128();
          run_block(d, 3'(s), fwd(3'(s), x), y, lat, ok);
          checks++;
          if (!ok || y !== x) begin
            failures++;
            $display("FAIL sweep_round_trip dut%0d sel%0d: got %h ok=%0d expected %h", d, s, y, ok, x);
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      sel_a[d]     = 3'd0;
      in_data_a[d] = '0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_zero();
    test_sel7();
    test_reset_mid_sub();
    test_round_trip();
    test_back_to_back();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
